// File: rtl/pci_bus_arbiter.sv
// Round-robin arbiter for the shared addressdata bus: one active-low grant at a time,
// grant revocation on timeout, and one turnaround cycle on every hand-over.
module pci_bus_arbiter #(
  parameter int NUM_DEV = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_DEV-1:0]         req_n,
  input  logic                       iframe,
  input  logic                       iready,
  output logic [NUM_DEV-1:0]         gnt_n,
  output logic [$clog2(NUM_DEV)-1:0] owner,
  output logic                       bus_busy,
  output logic [1:0]                 state_dbg
);

  localparam int OW = $clog2(NUM_DEV);
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TIMER_MAX  = {TW{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_OWNED = 2'd2,
    S_TURN  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_DEV-1:0]   gnt_q, gnt_d;
  logic [OW-1:0]        owner_q, owner_d;
  logic [OW-1:0]        rr_q, rr_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic                 busy_q, busy_d;
  logic                 bus_idle;
  logic                 win_found;
  logic [OW-1:0]        win_idx;
  int                   cand;

  assign bus_idle = iframe & iready;

  // First low request scanning upward from rr_q, wrapping at NUM_DEV-1.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int i = 0; i < NUM_DEV; i++) begin
      cand = (int'(rr_q) + i) % NUM_DEV;
      if (!win_found && !req_n[cand]) begin
        win_found = 1'b1;
        win_idx   = OW'(cand);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    timer_d = timer_q;
    busy_d  = busy_q;
    case (state_q)
      S_IDLE: begin
        if (win_found && bus_idle) begin
          gnt_d   = ~(NUM_DEV'(1) << win_idx);
          owner_d = win_idx;
          timer_d = '0;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        // Frame start wins over withdrawal and timeout in the same cycle.
        if (!iframe) begin
          gnt_d   = {NUM_DEV{1'b1}};
          busy_d  = 1'b1;
          state_d = S_OWNED;
        end else if (req_n[owner_q]) begin
          gnt_d   = {NUM_DEV{1'b1}};
          state_d = S_TURN;
        end else if (timer_q == TIMER_LAST) begin
          gnt_d   = {NUM_DEV{1'b1}};
          state_d = S_TURN;
        end else if (timer_q != TIMER_MAX) begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_OWNED: begin
        if (bus_idle) begin
          busy_d  = 1'b0;
          state_d = S_TURN;
        end
      end
      S_TURN: begin
        rr_d    = (owner_q == OW'(NUM_DEV - 1)) ? '0 : owner_q + 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        gnt_d   = {NUM_DEV{1'b1}};
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      gnt_q   <= {NUM_DEV{1'b1}};
      owner_q <= '0;
      rr_q    <= '0;
      timer_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      timer_q <= timer_d;
      busy_q  <= busy_d;
    end
  end

  assign gnt_n     = gnt_q;
  assign owner     = owner_q;
  assign bus_busy  = busy_q;
  assign state_dbg = state_q;

endmodule
